// File: rtl/div_rcp_seq.sv
// div_rcp_seq: sequential reciprocal generator for the vector divide path.
// Normalizes a 15-bit divisor, then retires one quotient bit per clock by
// radix-2 restoring division to give rcp = floor(2^29 / dn) and the applied
// leading-zero shift. Define DIV_RCP_ROUND_EN to add a rounding state
// (round to nearest, ties up); otherwise the result is truncated.
module div_rcp_seq (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        start,
    input  logic [14:0] din,
    output logic        busy,
    output logic        done,
    output logic [15:0] rcp,
    output logic [3:0]  shift,
    output logic        dz
);

`ifdef DIV_RCP_ROUND_EN
    typedef enum logic [2:0] {IDLE, NORM, ITER, RND, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, NORM, ITER, DONE} state_t;
`endif

    state_t      state, state_nxt;
    logic        accept;
    logic [14:0] din_q;     // captured divisor
    logic [14:0] dn;        // normalized divisor, dn[14] = 1
    logic [3:0]  lz;        // leading zeros removed from din_q
    logic [3:0]  cnt;       // quotient bit being resolved
    logic [15:0] r;         // partial remainder
    logic [15:0] q;         // quotient accumulator
    logic [3:0]  lz_c;
    logic [14:0] dn_c;
    logic        ge;
    logic [15:0] r_sub;
    logic [15:0] q_nxt;

    // State register
    always_ff @(posedge clk or negedge reset_l) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values.
        if (!reset_l) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic and status decode
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    accept = 1'b1;
                    if (din == 15'd0) state_nxt = DONE;
                    else              state_nxt = NORM;
                end else begin
                    state_nxt = IDLE;
                end
            end
            NORM: begin
                busy      = 1'b1;
                state_nxt = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
`ifdef DIV_RCP_ROUND_EN
                    state_nxt = RND;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef DIV_RCP_ROUND_EN
            RND: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Leading-zero count and normalized divisor of the captured operand
    always_comb begin
        lz_c = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (din_q[i]) lz_c = 4'(14 - i);
        end
        dn_c = din_q << lz_c;
    end

    // One restoring step: trial subtract and quotient bit; also the RND compare
    always_comb begin
        ge    = (r >= {1'b0, dn});
        r_sub = ge ? (r - {1'b0, dn}) : r;
        q_nxt = q;
        if (ge) q_nxt[cnt] = 1'b1;
    end

    // Operand capture, normalization, iteration and result registers
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            din_q <= '0;
            dn    <= '0;
            lz    <= '0;
            cnt   <= '0;
            r     <= '0;
            q     <= '0;
            rcp   <= '0;
            shift <= '0;
            dz    <= 1'b0;
        end else begin
            if (accept) begin
                din_q <= din;
                if (din == 15'd0) begin
                    rcp   <= 16'hFFFF;
                    shift <= 4'd0;
                    dz    <= 1'b1;
                end
            end
            case (state)
                NORM: begin
                    dn  <= dn_c;
                    lz  <= lz_c;
                    r   <= 16'h4000;
                    q   <= '0;
                    cnt <= 4'd15;
                end
                ITER: begin
                    // r_sub < dn < 2^15, so the shift cannot lose a bit
                    r   <= r_sub << 1;
                    q   <= q_nxt;
                    cnt <= cnt - 4'd1;
`ifndef DIV_RCP_ROUND_EN
                    if (cnt == 4'd0) begin
                        rcp   <= q_nxt;
                        shift <= lz;
                        dz    <= 1'b0;
                    end
`endif
                end
`ifdef DIV_RCP_ROUND_EN
                RND: begin
                    // r already holds 2*remainder; round up when it reaches dn
                    rcp   <= q + {15'd0, ge};
                    shift <= lz;
                    dz    <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_rcp_seq.sv
// tb_div_rcp_seq: self-checking bench for div_rcp_seq. An arithmetic model
// predicts busy/done/rcp/shift/dz every cycle; directed operations also carry
// hand-computed literals. Honors DIV_RCP_ROUND_EN like the design.
module tb_div_rcp_seq;

`ifdef DIV_RCP_ROUND_EN
    localparam int LAT    = 18;
    localparam bit RND_EN = 1'b1;
`else
    localparam int LAT    = 17;
    localparam bit RND_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_l = 1'b1;
    logic        start = 1'b0;
    logic [14:0] din = '0;
    logic        busy, done, dz;
    logic [15:0] rcp;
    logic [3:0]  shift;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    div_rcp_seq dut (
        .clk     (clk),
        .reset_l (reset_l),
        .start   (start),
        .din     (din),
        .busy    (busy),
        .done    (done),
        .rcp     (rcp),
        .shift   (shift),
        .dz      (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Number of left shifts that bring d into [2^14, 2^15)
    function automatic int ref_shift(input logic [14:0] d);
        int s = 0;
        int v = int'(d);
        if (d == 15'd0) return 0;
        while (v < 'h4000) begin
            v = v << 1;
            s++;
        end
        return s;
    endfunction

    // 2^29 / dn, truncated or rounded to nearest with ties up
    function automatic logic [15:0] ref_rcp(input logic [14:0] d);
        longint one = 1;
        longint dn;
        if (d == 15'd0) return 16'hFFFF;
        dn = longint'(d) << ref_shift(d);
        if (RND_EN) return 16'(((one << 30) + dn) / (2 * dn));
        return 16'((one << 29) / dn);
    endfunction

    // Transaction-level model: which cycle each result appears in and what it is
    int          cyc = 0;
    bit          m_active = 1'b0, m_nz = 1'b0, m_acc;
    int          m_done = 0;
    logic [15:0] m_rcp, h_rcp = '0;
    logic [3:0]  m_shift, h_shift = '0;
    logic        m_dz, h_dz = 1'b0;

    always @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            m_active = 1'b0;
            h_rcp    = '0;
            h_shift  = '0;
            h_dz     = 1'b0;
        end else begin
            m_acc = start && !(m_active && m_nz && cyc < m_done);
            cyc++;
            if (m_acc) begin
                m_active = 1'b1;
                m_nz     = (din != 15'd0);
                m_done   = m_nz ? cyc + LAT : cyc;
                m_rcp    = ref_rcp(din);
                m_shift  = 4'(ref_shift(din));
                m_dz     = (din == 15'd0);
            end
            if (m_active && cyc == m_done) begin
                h_rcp   = m_rcp;
                h_shift = m_shift;
                h_dz    = m_dz;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  32'(busy),  32'(m_active && m_nz && cyc < m_done));
            check("done",  32'(done),  32'(m_active && cyc == m_done));
            check("rcp",   32'(rcp),   32'(h_rcp));
            check("shift", 32'(shift), 32'(h_shift));
            check("dz",    32'(dz),    32'(h_dz));
        end
    end

    // Issue one request at the current negedge and wait for its done.
    // Latency is counted in clock edges after the sampling edge; din==0 enters
    // DONE on the sampling edge itself, so its done is seen right after it.
    // poke>0 pulses start with din=7FFF while the operation is in flight.
    task automatic run_op(input logic [14:0] d, input logic [15:0] er, input logic [3:0] es,
                          input logic ez, input int elat, input int poke);
        int n;
        bit seen;
        start = 1'b1;
        din   = d;
        @(posedge clk);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                n++;
                start = (n == poke);
                if (n == poke) din = 15'h7FFF;
            end
        end
        start = 1'b0;
        check($sformatf("done_seen_%0h", d), 32'(seen), 32'd1);
        if (seen) begin
            check($sformatf("latency_%0h", d), 32'(n),     32'(elat));
            check($sformatf("rcp_%0h", d),     32'(rcp),   32'(er));
            check($sformatf("shift_%0h", d),   32'(shift), 32'(es));
            check($sformatf("dz_%0h", d),      32'(dz),    32'(ez));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int dcnt;
        // Pin the model to hand-computed values
        check("model_4000", 32'(ref_rcp(15'h4000)), 32'h8000);
        check("model_7fff", 32'(ref_rcp(15'h7FFF)), RND_EN ? 32'h4001 : 32'h4000);
        check("model_0003", 32'(ref_rcp(15'h0003)), 32'h5555);
        check("model_sh_3", 32'(ref_shift(15'h0003)), 32'd13);
        check("model_5555", 32'(ref_rcp(15'h5555)), 32'h6000);

        #1 reset_l = 1'b0;
        #1 chk_en  = 1'b1;
        @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_rcp",   32'(rcp),   32'd0);
        check("rst_shift", 32'(shift), 32'd0);
        check("rst_dz",    32'(dz),    32'd0);
        @(negedge clk);
        #2 reset_l = 1'b1;
        @(negedge clk);

        run_op(15'h4000, 16'h8000, 4'd0, 1'b0, LAT, -1);
        @(negedge clk);
        run_op(15'h7FFF, RND_EN ? 16'h4001 : 16'h4000, 4'd0, 1'b0, LAT, -1);
        @(negedge clk);
        run_op(15'h0003, 16'h5555, 4'd13, 1'b0, LAT, -1);
        @(negedge clk);
        run_op(15'h0001, 16'h8000, 4'd14, 1'b0, LAT, -1);
        @(negedge clk);
        run_op(15'h0000, 16'hFFFF, 4'd0, 1'b1, 0, -1);
        @(negedge clk);
        run_op(15'h6000, 16'h5555, 4'd0, 1'b0, LAT, -1);
        @(negedge clk);

        // Start pulsed while busy is ignored; then a start in the DONE cycle
        run_op(15'h4000, 16'h8000, 4'd0, 1'b0, LAT, 5);
        run_op(15'h7FFF, RND_EN ? 16'h4001 : 16'h4000, 4'd0, 1'b0, LAT, -1);
        run_op(15'h1234, ref_rcp(15'h1234), 4'(ref_shift(15'h1234)), 1'b0, LAT, -1);
        @(negedge clk);
        run_op(15'h2AAA, ref_rcp(15'h2AAA), 4'(ref_shift(15'h2AAA)), 1'b0, LAT, -1);
        @(negedge clk);
        run_op(15'h7001, ref_rcp(15'h7001), 4'(ref_shift(15'h7001)), 1'b0, LAT, -1);
        @(negedge clk);

        // Reset in the middle of an operation
        start = 1'b1;
        din   = 15'h5555;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset_l = 1'b0;
        @(negedge clk);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_rcp",   32'(rcp),   32'd0);
        check("abort_shift", 32'(shift), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset_l = 1'b1;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("no_done_after_abort", 32'(dcnt), 32'd0);
        run_op(15'h5555, 16'h6000, 4'd0, 1'b0, LAT, -1);
        @(negedge clk);
        @(negedge clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
